// File: rtl/mips_step_sequencer.sv
// Multi-cycle step sequencer for a MIPS datapath. It owns the PC, walks each instruction
// through fetch/decode/execute/memory/writeback and gates register and memory write strobes.
module mips_step_sequencer #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step_req,
    input  logic [31:0]          instruction,
    input  logic                 mem_ready,
    output logic [31:0]          pc,
    output logic                 ir_valid,
    output logic                 reg_write_en,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFetch    = 3'd1,
        StDecode   = 3'd2,
        StExec     = 3'd3,
        StMem      = 3'd4,
        StWb       = 3'd5,
        StHalted   = 3'd6,
        StWaitStep = 3'd7
    } state_e;

    typedef enum logic [2:0] {OpR, OpLw, OpSw, OpJ, OpHalt, OpNop} op_e;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e               state_q;
    op_e                  op_q;
    logic [31:0]          pc_q;
    logic [31:0]          ir_q;
    logic                 ir_valid_q;
    logic                 reg_write_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic                 halted_q;
    logic                 timeout_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [7:0]           wait_q;
    state_e               after_retire;

    function automatic op_e decode_op(input logic [5:0] opc);
        case (opc)
            6'b000000: return OpR;
            6'b100011: return OpLw;
            6'b101011: return OpSw;
            6'b000010: return OpJ;
            6'b111111: return OpHalt;
            default:   return OpNop;
        endcase
    endfunction

    // step_mode is only looked at when an instruction retires
    assign after_retire = step_mode ? StWaitStep : StFetch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OpNop;
            pc_q        <= PC_RESET;
            ir_q        <= 32'h0;
            ir_valid_q  <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
            wait_q      <= 8'd0;
        end else begin
            reg_write_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) state_q <= StFetch;
                end
                StFetch: begin
                    ir_q       <= instruction;
                    ir_valid_q <= 1'b1;
                    state_q    <= StDecode;
                end
                StDecode: begin
                    op_q    <= decode_op(ir_q[31:26]);
                    state_q <= StExec;
                end
                StExec: begin
                    case (op_q)
                        OpJ: begin
                            pc_q       <= {pc_q[31:28], ir_q[25:0], 2'b00};
                            count_q    <= count_q + CNT_WIDTH'(1);
                            ir_valid_q <= 1'b0;
                            state_q    <= after_retire;
                        end
                        OpHalt: begin
                            count_q    <= count_q + CNT_WIDTH'(1);
                            ir_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                            state_q    <= StHalted;
                        end
                        OpLw: begin
                            mem_read_q <= 1'b1;
                            wait_q     <= 8'd0;
                            state_q    <= StMem;
                        end
                        OpSw: begin
                            mem_write_q <= 1'b1;
                            wait_q      <= 8'd0;
                            state_q     <= StMem;
                        end
                        OpR: begin
                            reg_write_q <= 1'b1;
                            state_q     <= StWb;
                        end
                        default: begin
                            pc_q       <= pc_q + 32'd4;
                            count_q    <= count_q + CNT_WIDTH'(1);
                            ir_valid_q <= 1'b0;
                            state_q    <= after_retire;
                        end
                    endcase
                end
                StMem: begin
                    if (mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (op_q == OpLw) begin
                            reg_write_q <= 1'b1;
                            state_q     <= StWb;
                        end else begin
                            pc_q       <= pc_q + 32'd4;
                            count_q    <= count_q + CNT_WIDTH'(1);
                            ir_valid_q <= 1'b0;
                            state_q    <= after_retire;
                        end
                    end else if (wait_q == WaitLast) begin
                        // abandon the access; pc stays on the faulting instruction
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        timeout_q   <= 1'b1;
                        halted_q    <= 1'b1;
                        state_q     <= StHalted;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StWb: begin
                    pc_q       <= pc_q + 32'd4;
                    count_q    <= count_q + CNT_WIDTH'(1);
                    ir_valid_q <= 1'b0;
                    state_q    <= after_retire;
                end
                StHalted: begin
                    if (start) begin
                        halted_q <= 1'b0;
                        state_q  <= StFetch;
                    end
                end
                StWaitStep: begin
                    if (step_req || !step_mode) state_q <= StFetch;
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign ir_valid     = ir_valid_q;
    assign reg_write_en = reg_write_q;
    assign mem_read_en  = mem_read_q;
    assign mem_write_en = mem_write_q;
    assign state        = state_q;
    assign busy         = (state_q != StIdle) && (state_q != StHalted);
    assign halted       = halted_q;
    assign instr_count  = count_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_mips_step_sequencer.sv
// Bench for mips_step_sequencer: directed scenarios plus a random program whose retirements
// are predicted by a cycle-count model and checked by a scoreboard monitor.
module tb_mips_step_sequencer;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, step_mode, step_req, mem_ready;
    logic [31:0]   instruction, pc;
    logic          ir_valid, reg_write_en, mem_read_en, mem_write_en, busy, halted, timeout_err;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    logic [31:0] imem [256];
    assign instruction = imem[pc[9:2]];

    always #5 clk = ~clk;

    mips_step_sequencer #(
        .PC_RESET    (32'h0000_0000),
        .MEM_TIMEOUT (8),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .step_mode    (step_mode),
        .step_req     (step_req),
        .instruction  (instruction),
        .mem_ready    (mem_ready),
        .pc           (pc),
        .ir_valid     (ir_valid),
        .reg_write_en (reg_write_en),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .state        (state),
        .busy         (busy),
        .halted       (halted),
        .instr_count  (instr_count),
        .timeout_err  (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory responder: each access waits the delay popped from delay_q before mem_ready.
    int delay_q[$];
    int cur_delay = 0;
    int rcnt = 0;
    bit noise_en = 1'b0;

    always @(negedge clk) begin
        if (mem_read_en || mem_write_en) begin
            if (rcnt == 0) cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
            mem_ready = (rcnt == cur_delay);
            rcnt++;
        end else begin
            rcnt = 0;
            mem_ready = noise_en ? 1'($urandom_range(1)) : 1'b0;
        end
    end

    // Scoreboard monitor: one expected record per retired instruction.
    typedef struct {
        logic [31:0]   pc_after;
        logic [CW-1:0] cnt_after;
        int            cyc;
        int            rw;
        int            rd;
        int            wr;
        logic          halt;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          got;
    bit            mon_en = 1'b0;
    logic [CW-1:0] prev_cnt = '0;
    int            acc_cyc, acc_rw, acc_rd, acc_wr;

    always @(negedge clk) begin
        if (!mon_en) begin
            acc_cyc = 0; acc_rw = 0; acc_rd = 0; acc_wr = 0;
        end else begin
            if (instr_count != prev_cnt) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'(instr_count), 32'(prev_cnt));
                end else begin
                    got = exp_q.pop_front();
                    check("ret_pc", pc, got.pc_after);
                    check("ret_count", 32'(instr_count), 32'(got.cnt_after));
                    check("ret_cycles", acc_cyc, got.cyc);
                    check("ret_reg_write_cycles", acc_rw, got.rw);
                    check("ret_mem_read_cycles", acc_rd, got.rd);
                    check("ret_mem_write_cycles", acc_wr, got.wr);
                    check("ret_halted", 32'(halted), 32'(got.halt));
                end
                acc_cyc = 0; acc_rw = 0; acc_rd = 0; acc_wr = 0;
            end
            if (state inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) begin
                acc_cyc++;
                acc_rw += int'(reg_write_en);
                acc_rd += int'(mem_read_en);
                acc_wr += int'(mem_write_en);
            end
            if ((reg_write_en || mem_read_en || mem_write_en) && !(state inside {3'd4, 3'd5}))
                check("strobe_outside_mem_wb", 32'(state), 32'd4);
            if (int'(reg_write_en) + int'(mem_read_en) + int'(mem_write_en) > 1)
                check("strobes_exclusive",
                      32'({reg_write_en, mem_read_en, mem_write_en}), 32'd0);
        end
        prev_cnt = instr_count;
    end

    // Per-cycle trace capture for the directed scenarios.
    logic [2:0]    st_tr [20];
    logic [31:0]   pc_tr [20];
    logic [CW-1:0] cnt_tr [20];
    logic          rw_tr [20], rd_tr [20], wr_tr [20], iv_tr [20];

    task automatic trace(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            st_tr[i]  = state;
            pc_tr[i]  = pc;
            cnt_tr[i] = instr_count;
            rw_tr[i]  = reg_write_en;
            rd_tr[i]  = mem_read_en;
            wr_tr[i]  = mem_write_en;
            iv_tr[i]  = ir_valid;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step_req = 1'b0; step_mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_halts();
        for (int i = 0; i < 256; i++) imem[i] = 32'hFC00_0000;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
        int n = 0;
        while (state !== s && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(state), 32'(s));
    endtask

    logic [2:0] exp1 [18];
    logic [2:0] exp2 [18];

    initial begin
        int sum_rw, sum_rd, sum_wr, sum_any, kind, d, tgt, idx, n;
        logic [31:0] ir, pcm;
        logic [5:0]  opc;
        exp_t        e;

        exp1 = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4,
                 3'd4, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd6, 3'd6, 3'd6};
        exp2 = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3,
                 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd6};

        // Scenario 1: reset values, then R-type, lw with 3 wait cycles, halt.
        fill_halts();
        imem[0] = 32'h0128_5020;
        imem[1] = 32'h8D28_0004;
        do_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_strobes", 32'({reg_write_en, mem_read_en, mem_write_en}), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        delay_q.push_back(3);
        start = 1'b1;
        trace(18);
        sum_rw = 0; sum_rd = 0; sum_wr = 0;
        for (int i = 0; i < 18; i++) begin
            check($sformatf("s1_state[%0d]", i), 32'(st_tr[i]), 32'(exp1[i]));
            sum_rw += int'(rw_tr[i]);
            sum_rd += int'(rd_tr[i]);
            sum_wr += int'(wr_tr[i]);
        end
        check("s1_rtype_wb_strobe", 32'(rw_tr[3]), 32'd1);
        check("s1_reg_write_cycles", sum_rw, 32'd2);
        check("s1_mem_read_cycles", sum_rd, 32'd4);
        check("s1_mem_write_cycles", sum_wr, 32'd0);
        check("s1_ir_valid_decode", 32'(iv_tr[1]), 32'd1);
        check("s1_ir_valid_retired", 32'(iv_tr[4]), 32'd0);
        check("s1_pc_after_rtype", pc_tr[4], 32'h4);
        check("s1_count_after_rtype", 32'(cnt_tr[4]), 32'd1);
        check("s1_pc_after_lw", pc_tr[12], 32'h8);
        check("s1_count_after_lw", 32'(cnt_tr[12]), 32'd2);
        check("s1_halt_pc", pc, 32'h8);
        check("s1_halt_count", 32'(instr_count), 32'd3);
        check("s1_halted", 32'(halted), 32'd1);
        check("s1_busy", 32'(busy), 32'd0);
        check("s1_timeout", 32'(timeout_err), 32'd0);

        // Scenario 2: j 0 -> 0x100, j 0x100 -> 0x40, sw at 0x40 never acknowledged.
        fill_halts();
        imem[0]    = 32'h0800_0040;
        imem[8'h40] = 32'h0800_0010;
        imem[8'h10] = 32'hAD09_0000;
        do_reset();
        delay_q.push_back(255);
        start = 1'b1;
        trace(18);
        sum_any = 0; sum_wr = 0;
        for (int i = 0; i < 18; i++) begin
            check($sformatf("s2_state[%0d]", i), 32'(st_tr[i]), 32'(exp2[i]));
            if (i < 9) sum_any += int'(rw_tr[i]) + int'(rd_tr[i]) + int'(wr_tr[i]);
            sum_wr += int'(wr_tr[i]);
        end
        check("s2_pc_after_first_j", pc_tr[3], 32'h100);
        check("s2_pc_after_second_j", pc_tr[6], 32'h40);
        check("s2_j_no_strobes", sum_any, 32'd0);
        check("s2_mem_write_cycles", sum_wr, 32'd8);
        check("s2_timeout_err", 32'(timeout_err), 32'd1);
        check("s2_halted", 32'(halted), 32'd1);
        check("s2_pc_unchanged", pc, 32'h40);
        check("s2_mem_write_dropped", 32'(mem_write_en), 32'd0);
        check("s2_count", 32'(instr_count), 32'd2);

        // Scenario 3: restart from HALTED keeps timeout_err; reset mid-MEM clears everything.
        delay_q.push_back(255);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s3_restart_state", 32'(state), 32'd1);
        check("s3_restart_halted", 32'(halted), 32'd0);
        check("s3_timeout_sticky", 32'(timeout_err), 32'd1);
        check("s3_restart_pc", pc, 32'h40);
        wait_state(3'd4, 10, "s3_reach_mem");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("s3_rst_state", 32'(state), 32'd0);
        check("s3_rst_pc", pc, 32'h0);
        check("s3_rst_count", 32'(instr_count), 32'd0);
        check("s3_rst_timeout", 32'(timeout_err), 32'd0);
        check("s3_rst_halted", 32'(halted), 32'd0);
        check("s3_rst_strobes", 32'({reg_write_en, mem_read_en, mem_write_en}), 32'd0);

        // Scenario 4: single-step over three R-types, then leave step mode into a halt.
        fill_halts();
        for (int i = 0; i < 3; i++) imem[i] = 32'h0128_5020;
        do_reset();
        step_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_state(3'd7, 20, $sformatf("s4_waitstep_%0d", k));
            check($sformatf("s4_count_%0d", k), 32'(instr_count), 32'(k));
            check($sformatf("s4_pc_%0d", k), pc, 32'(4 * k));
            repeat (3) @(negedge clk);
            check($sformatf("s4_hold_%0d", k), 32'(state), 32'd7);
            check($sformatf("s4_hold_count_%0d", k), 32'(instr_count), 32'(k));
            if (k < 3) step_req = 1'b1;
            else step_mode = 1'b0;
            @(negedge clk);
            step_req = 1'b0;
            check($sformatf("s4_advance_%0d", k), 32'(state), 32'd1);
        end
        wait_state(3'd6, 20, "s4_halt");
        check("s4_final_count", 32'(instr_count), 32'd4);
        check("s4_final_pc", pc, 32'hC);

        // Scenario 5: random forward-flowing program, free-run, random memory latency.
        fill_halts();
        do_reset();
        idx = 0;
        pcm = 32'h0;
        n = 0;
        while (n < 40 && idx < 240) begin
            kind = $urandom_range(4);
            d = $urandom_range(4);
            e.pc_after = pcm + 32'd4;
            e.rw = 0; e.rd = 0; e.wr = 0; e.halt = 1'b0;
            case (kind)
                0: begin ir = {6'b000000, 26'($urandom)}; e.cyc = 4; e.rw = 1; end
                1: begin
                    ir = {6'b100011, 26'($urandom)};
                    e.cyc = 5 + d; e.rw = 1; e.rd = d + 1;
                    delay_q.push_back(d);
                end
                2: begin
                    ir = {6'b101011, 26'($urandom)};
                    e.cyc = 4 + d; e.wr = d + 1;
                    delay_q.push_back(d);
                end
                3: begin
                    tgt = idx + 1 + int'($urandom_range(3));
                    ir = {6'b000010, 26'(tgt)};
                    e.cyc = 3;
                    e.pc_after = 32'(tgt * 4);
                end
                default: begin
                    opc = 6'($urandom);
                    while (opc inside {6'b000000, 6'b100011, 6'b101011, 6'b000010, 6'b111111})
                        opc = 6'($urandom);
                    ir = {opc, 26'($urandom)};
                    e.cyc = 3;
                end
            endcase
            n++;
            e.cnt_after = CW'(n);
            imem[idx] = ir;
            exp_q.push_back(e);
            pcm = e.pc_after;
            idx = int'(pcm >> 2);
        end
        imem[idx] = 32'hFC00_0000;
        e.pc_after = pcm; e.cnt_after = CW'(n + 1); e.cyc = 3;
        e.rw = 0; e.rd = 0; e.wr = 0; e.halt = 1'b1;
        exp_q.push_back(e);

        noise_en = 1'b1;
        mon_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(3'd6, 3000, "s5_reach_halt");
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        noise_en = 1'b0;
        check("s5_scoreboard_drained", exp_q.size(), 32'd0);
        check("s5_final_count", 32'(instr_count), 32'(n + 1));
        check("s5_final_pc", pc, pcm);
        check("s5_no_timeout", 32'(timeout_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_step_sequencer.md
Name: mips_step_sequencer

Overview:
Multi-cycle sequencer for the MIPS datapath: instruction memory, control unit, register decoder, ALU and main memory. It owns the PC and splits each instruction into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It gates register-file and memory writes so each instruction commits exactly once. It supports free-run and single-step modes and a ready handshake with main memory.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 8, max cycles waiting for mem_ready before error (1..255)
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
start  input  1  pulse: leave IDLE/HALTED and begin executing at current pc
step_mode  input  1  1 = single-step, 0 = free-run
step_req  input  1  pulse: permit one instruction in step mode
instruction  input  32  word from instruction memory at pc (combinational)
mem_ready  input  1  main memory access complete
pc  output  32  program counter to instruction memory
ir_valid  output  1  instruction register latched, datapath inputs stable
reg_write_en  output  1  one-cycle register-file write strobe
mem_read_en  output  1  main memory read request
mem_write_en  output  1  main memory write request
state  output  3  current FSM state code
busy  output  1  1 in any state other than IDLE/HALTED
halted  output  1  halt opcode retired or timeout occurred
instr_count  output  CNT_WIDTH  retired instructions, wraps
timeout_err  output  1  sticky, set on memory timeout

Behaviour:
- Reset (rst_n=0 at clk edge, any state): state=IDLE(0), pc=PC_RESET, all strobes 0, ir_valid=0, busy=0, halted=0, instr_count=0, timeout_err=0, wait counter=0. Reset overrides every other input on that edge.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, WAITSTEP=7.
- IDLE: on start -> FETCH. Otherwise stay.
- FETCH (1 cycle): latch instruction into internal IR, ir_valid<=1 -> DECODE.
- DECODE (1 cycle): classify IR[31:26].
  - 000000 R-type, 100011 lw, 101011 sw, 000010 j, 111111 halt.
  - Any other opcode is treated as a NOP.
  - Then -> EXEC.
- EXEC (1 cycle):
  - j: pc <= {pc[31:28], IR[25:0], 2'b00}; retire; -> next.
  - halt: retire; halted<=1; -> HALTED; pc is not advanced.
  - lw/sw: -> MEM.
  - R-type: -> WB.
  - NOP: pc<=pc+4; retire; -> next.
- MEM:
  - lw asserts mem_read_en; sw asserts mem_write_en. Held level while in MEM.
  - mem_ready=1 in a MEM cycle completes the access. lw -> WB. sw: pc<=pc+4, retire, -> next.
  - Wait counter increments each MEM cycle without mem_ready. Reaching MEM_TIMEOUT sets timeout_err=1 and halted=1 and drops strobes -> HALTED. pc is unchanged.
  - mem_ready outside MEM is ignored.
- WB (1 cycle): reg_write_en=1 for exactly this cycle; pc<=pc+4; retire -> next.
- Retire: instr_count<=instr_count+1 (modulo 2^CNT_WIDTH); ir_valid<=0.
- "next":
  - step_mode=0: -> FETCH.
  - step_mode=1: -> WAITSTEP.
- WAITSTEP: on step_req -> FETCH. If step_mode is cleared while waiting, -> FETCH next cycle.
- step_mode and step_req are sampled only at retire and in WAITSTEP. A mid-instruction change of step_mode does not abort the instruction.
- HALTED: all strobes 0, busy=0. On start:
  - halted<=0, -> FETCH.
  - pc is not advanced past a halt, so restarting re-executes it. Software must patch the program.
  - timeout_err stays set until reset.
- start is ignored while busy.
- Strobes are registered outputs, decoded from state and the latched IR.
  - Never more than one of reg_write_en/mem_read_en/mem_write_en is high at once.
  - No strobe is high in IDLE/FETCH/DECODE/EXEC/HALTED/WAITSTEP.
- pc wrap: pc+4 from 32'hFFFF_FFFC gives 0, with no error.
- Latency, free-run, zero-wait memory (state visits counted from FETCH through the final state before the next FETCH):
  - R-type = 4 cycles
  - lw = 5
  - sw = 4
  - j/NOP = 3

Test Plan:
- Reset then start with R-type (IR=32'h0128_5020) at pc=0: states 1,2,3,5,1. reg_write_en high one cycle. pc=4 after WB. instr_count=1.
- lw at pc=4, mem_ready delayed 3 cycles: mem_read_en high 4 cycles. WB follows. pc=8. No timeout.
- sw with mem_ready never asserted, MEM_TIMEOUT=8: after 8 MEM cycles, timeout_err=1, halted=1, state=6, pc unchanged, mem_write_en=0.
- j with IR=32'h0800_0010 at pc=32'h0000_0100: pc becomes 32'h0000_0040 after EXEC. No strobes. Next state FETCH.
- step_mode=1 over three R-types: each stops in WAITSTEP (state 7). Each step_req advances exactly one instruction. instr_count increments by 1 per step_req.
- halt opcode 32'hFC00_0000: halted=1, busy=0, pc unchanged. Assert rst_n=0 mid-MEM of a later run: next edge gives state=0, pc=PC_RESET, counters cleared.
